// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU request scheduler.
// Opcode set, scheduler states and the quiet-NaN error result.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_SQRT = 3'd4
    } fpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Codes above SQRT are never sent to the core.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_SQRT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fpu_req_sched.sv
// Shares one FPU core among NREQ requesters with round-robin arbitration.
// One op in flight; results return on a shared bus with a per-requester valid.
module fpu_req_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][31:0]      req_opA,
    input  logic [NREQ-1:0][31:0]      req_opB,
    input  logic [NREQ-1:0][2:0]       req_op,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [31:0]                rsp_result,
    output logic                       rsp_err,
    output logic                       fpu_start,
    output logic [31:0]                fpu_opA,
    output logic [31:0]                fpu_opB,
    output logic [2:0]                 fpu_op,
    input  logic                       fpu_done,
    input  logic [31:0]                fpu_result,
    output logic                       busy
);

    import fpu_ctrl_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_e    state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   next_ptr;
    logic [NREQ-1:0] arb_gnt;
    logic [TW-1:0]   timer;
    logic [31:0]     result_q;
    logic            err_q;
    logic            rsp_done;
    logic            timed_out;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Gated by rst so nothing looks accepted while reset is held.
    assign req_ready  = (state == S_IDLE && !rst) ? arb_gnt : '0;
    assign busy       = (state != S_IDLE);
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign rsp_done   = |(rsp_valid & rsp_ready);
    assign timed_out  = (timer == TW'(TIMEOUT - 1));
    assign next_ptr   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            timer     <= '0;
            fpu_start <= 1'b0;
            fpu_opA   <= '0;
            fpu_opB   <= '0;
            fpu_op    <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            rsp_valid <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        gidx    <= arb_idx;
                        rr_ptr  <= next_ptr;
                        fpu_opA <= req_opA[arb_idx];
                        fpu_opB <= req_opB[arb_idx];
                        fpu_op  <= req_op[arb_idx];
                        if (op_legal(req_op[arb_idx])) begin
                            fpu_start <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            result_q  <= QNAN;
                            err_q     <= 1'b1;
                            rsp_valid <= arb_gnt;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    fpu_start <= 1'b0;
                    timer     <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // A completion on the last allowed cycle beats the timeout.
                    if (fpu_done) begin
                        result_q  <= fpu_result;
                        err_q     <= 1'b0;
                        rsp_valid <= NREQ'(1) << gidx;
                        state     <= S_RESP;
                    end else if (timed_out) begin
                        result_q  <= QNAN;
                        err_q     <= 1'b1;
                        rsp_valid <= NREQ'(1) << gidx;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_done) begin
                        rsp_valid <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_sched.sv
// Randomised bench for fpu_req_sched against a transaction-level model.
// The model tracks pending requests, the round-robin pointer and response timing.
module tb_fpu_req_sched;

    import fpu_ctrl_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_opA;
    logic [NREQ-1:0][31:0] req_opB;
    logic [NREQ-1:0][2:0]  req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_err;
    logic                  fpu_start;
    logic [31:0]           fpu_opA;
    logic [31:0]           fpu_opB;
    logic [2:0]            fpu_op;
    logic                  fpu_done;
    logic [31:0]           fpu_result;
    logic                  busy;

    int ncmp  = 0;
    int nfail = 0;

    bit          pend [NREQ];
    logic [31:0] m_a  [NREQ];
    logic [31:0] m_b  [NREQ];
    logic [2:0]  m_op [NREQ];
    int          ptr;

    always #5 clk = ~clk;

    fpu_req_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opA    (req_opA),
        .req_opB    (req_opB),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .fpu_start  (fpu_start),
        .fpu_opA    (fpu_opA),
        .fpu_opB    (fpu_opB),
        .fpu_op     (fpu_op),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Done is a one-cycle pulse: cleared right after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        fpu_done = 1'b0;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i];
            req_opA[i]   = m_a[i];
            req_opB[i]   = m_b[i];
            req_op[i]    = m_op[i];
        end
    endtask

    task automatic post(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op);
        pend[i] = 1'b1;
        m_a[i]  = a;
        m_b[i]  = b;
        m_op[i] = op;
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
    endtask

    // One full transaction: grant, optional core run, response, release.
    // d = ticks after start at which the core raises done (0 = during start).
    task automatic do_op(input int d, input int hold,
                         input logic [31:0] res, output int gi);
        int              g;
        int              expc;
        bit              experr;
        logic [31:0]     expres;
        logic [NREQ-1:0] oh;
        g  = -1;
        gi = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        if (g < 0) begin
            $display("FAIL do_op: no pending request got %0d want >=0", g);
            $fatal(1);
        end
        oh = onehot(g);
        #1;
        chk("ready", req_ready, oh);
        for (int i = 0; i < NREQ; i++)
            if (gi < 0 && req_ready[i]) gi = i;
        tick();
        pend[g] = 1'b0;
        ptr     = (g + 1) % NREQ;
        drive();
        chk("busy_acc", busy, 1);
        if (m_op[g] > 3'd4) begin
            experr = 1'b1;
            expres = QNAN;
            chk("ill_start", fpu_start, 0);
            chk("ill_valid", rsp_valid, oh);
        end else begin
            experr = (d == 0 || d > TIMEOUT);
            expc   = experr ? TIMEOUT + 1 : d + 1;
            expres = experr ? QNAN : res;
            chk("start", fpu_start, 1);
            chk("opA", fpu_opA, m_a[g]);
            chk("opB", fpu_opB, m_b[g]);
            chk("op", fpu_op, m_op[g]);
            if (d == 0) begin
                fpu_done   = 1'b1;
                fpu_result = ~res;
            end
            for (int t = 1; t <= expc; t++) begin
                tick();
                chk("start_once", fpu_start, 0);
                chk("rsp_time", rsp_valid, (t == expc) ? oh : '0);
                if (t < expc) chk("opA_hold", fpu_opA, m_a[g]);
                if (t == d) begin
                    fpu_done   = 1'b1;
                    fpu_result = (t == expc) ? ~res : res;
                end
            end
        end
        chk("rsp_err", rsp_err, experr);
        chk("rsp_res", rsp_result, expres);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = NREQ'($urandom) & ~oh;
            #1;
            chk("no_accept", req_ready, 0);
            tick();
            chk("hold_valid", rsp_valid, oh);
            chk("hold_res", rsp_result, expres);
            chk("hold_err", rsp_err, experr);
        end
        rsp_ready = oh | NREQ'($urandom);
        tick();
        rsp_ready = '0;
        chk("rsp_clear", rsp_valid, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int gi;
        int d;
        rst        = 1'b1;
        rsp_ready  = '0;
        fpu_done   = 1'b0;
        fpu_result = '0;
        ptr        = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            m_a[i]  = '0;
            m_b[i]  = '0;
            m_op[i] = '0;
        end
        drive();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", fpu_start, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_res", rsp_result, 0);
        chk("rst_opA", fpu_opA, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", req_ready, 0);

        // fairness: all four held, core answers one cycle after start
        for (int i = 0; i < NREQ; i++)
            post(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
        for (int k = 0; k < 6; k++) begin
            do_op(1, 0, $urandom, gi);
            chk("fair_seq", gi, k % NREQ);
            post(gi, $urandom, $urandom, 3'($urandom_range(0, 4)));
        end
        clear_all();

        // single ADD with three-cycle core latency
        post(0, 32'h3F80_0000, 32'h4000_0000, 3'(OP_ADD));
        do_op(3, 0, 32'h4040_0000, gi);
        chk("single_g", gi, 0);

        // illegal opcode
        post(2, $urandom, $urandom, 3'd6);
        do_op(2, 1, $urandom, gi);
        chk("ill_g", gi, 2);

        // timeout, then a late done while idle
        post(1, $urandom, $urandom, 3'(OP_DIV));
        do_op(TIMEOUT + 4, 0, $urandom, gi);
        fpu_done   = 1'b1;
        fpu_result = 32'h1234_5678;
        tick();
        chk("late_busy", busy, 0);
        chk("late_rspv", rsp_valid, 0);
        chk("late_start", fpu_start, 0);

        // done ignored during start cycle, and done one cycle late
        post(3, $urandom, $urandom, 3'(OP_SQRT));
        do_op(0, 0, $urandom, gi);
        post(3, $urandom, $urandom, 3'(OP_MUL));
        do_op(TIMEOUT + 1, 0, $urandom, gi);

        // done on the last allowed cycle wins
        post(0, $urandom, $urandom, 3'(OP_SUB));
        do_op(TIMEOUT, 0, 32'h4120_0000, gi);

        // backpressure with competing requesters
        post(1, $urandom, $urandom, 3'(OP_ADD));
        post(3, $urandom, $urandom, 3'(OP_MUL));
        do_op(2, 10, $urandom, gi);
        do_op(1, 0, $urandom, gi);

        // reset while waiting on the core
        clear_all();
        post(1, $urandom, $urandom, 3'(OP_MUL));
        tick();
        pend[1] = 1'b0;
        drive();
        chk("ab_start", fpu_start, 1);
        tick();
        tick();
        chk("ab_busy", busy, 1);
        post(3, $urandom, $urandom, 3'(OP_ADD));
        rst = 1'b1;
        #1;
        chk("ab_busy0", busy, 0);
        chk("ab_start0", fpu_start, 0);
        chk("ab_ready0", req_ready, 0);
        chk("ab_opA0", fpu_opA, 0);
        chk("ab_opB0", fpu_opB, 0);
        chk("ab_op0", fpu_op, 0);
        chk("ab_res0", rsp_result, 0);
        chk("ab_err0", rsp_err, 0);
        tick();
        rst = 1'b0;
        ptr = 0;
        clear_all();
        for (int k = 0; k < 4; k++) begin
            fpu_done = (k == 0);
            tick();
            chk("ab_norsp", rsp_valid, 0);
            chk("ab_idle", busy, 0);
        end
        for (int i = 0; i < NREQ; i++)
            post(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
        do_op(1, 0, $urandom, gi);
        chk("ab_ptr0", gi, 0);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    post(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
                else if (pend[i] && $urandom_range(0, 7) == 0)
                    pend[i] = 1'b0;
            end
            drive();
            if (!(pend[0] || pend[1] || pend[2] || pend[3]))
                post(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom,
                     3'($urandom_range(0, 7)));
            d = int'($urandom_range(0, TIMEOUT + 3));
            do_op(d, int'($urandom_range(0, 3)), $urandom, gi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
